// File: rtl/single_arg_port_arbiter.sv
// Shares one scalar-argument storage port among NUM_REQ requesters, one grant per cycle.
// Round-robin by default; define SINGLE_ARG_ARB_FIXED_PRIO_EN for lowest-index-wins priority.
module single_arg_port_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          done,
  input  logic [NUM_REQ-1:0]            req_ce,
  input  logic [NUM_REQ-1:0]            req_we,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_din,
  output logic [NUM_REQ-1:0]            grant,
  output logic [NUM_REQ-1:0]            rvalid,
  output logic [DATA_WIDTH-1:0]         rdata,
  output logic                          ce0,
  output logic                          we0,
  output logic [DATA_WIDTH-1:0]         mem_din0,
  input  logic [DATA_WIDTH-1:0]         mem_dout0
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    IDLE,
    ACTIVE,
    FROZEN
  } state_t;

  state_t             r_state;
  state_t             w_nextState;
  logic [PTR_W-1:0]   r_ptr;
  logic [PTR_W-1:0]   w_nextPtr;
  logic [PTR_W-1:0]   w_gntIdx;
  logic               w_found;
  logic [NUM_REQ-1:0] r_rdTag;

  // Winner search is suppressed entirely while the testbench owns storage or reset is held,
  // so requests simply wait rather than being consumed.
  always_comb begin
    w_found  = 1'b0;
    w_gntIdx = '0;
    if (!rst && !done) begin
      for (int k = 0; k < NUM_REQ; k++) begin
`ifdef SINGLE_ARG_ARB_FIXED_PRIO_EN
        if (!w_found && req_ce[k]) begin
          w_found  = 1'b1;
          w_gntIdx = PTR_W'(k);
        end
`else
        if (!w_found && req_ce[(int'(r_ptr) + k) % NUM_REQ]) begin
          w_found  = 1'b1;
          w_gntIdx = PTR_W'((int'(r_ptr) + k) % NUM_REQ);
        end
`endif
      end
    end
  end

  always_comb begin
    grant    = '0;
    ce0      = 1'b0;
    we0      = 1'b0;
    mem_din0 = '0;
    if (w_found) begin
      grant[w_gntIdx] = 1'b1;
      ce0             = 1'b1;
      we0             = req_we[w_gntIdx];
      mem_din0        = req_din[int'(w_gntIdx)*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  always_comb begin
`ifdef SINGLE_ARG_ARB_FIXED_PRIO_EN
    w_nextPtr = '0;
`else
    w_nextPtr = r_ptr;
    if (w_found) begin
      w_nextPtr = (w_gntIdx == PTR_W'(NUM_REQ-1)) ? '0 : w_gntIdx + 1'b1;
    end
`endif
  end

  always_comb begin
    w_nextState = r_state;
    if (done) begin
      w_nextState = FROZEN;
    end else begin
      case (r_state)
        IDLE:    w_nextState = w_found ? ACTIVE : IDLE;
        ACTIVE:  w_nextState = w_found ? ACTIVE : IDLE;
        FROZEN:  w_nextState = IDLE;
        default: w_nextState = IDLE;
      endcase
    end
  end

  // Read tags are registered independently of done so a read granted just before a freeze
  // still returns its data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_ptr   <= '0;
      r_rdTag <= '0;
    end else begin
      r_state <= w_nextState;
      r_ptr   <= w_nextPtr;
      r_rdTag <= grant & ~req_we;
    end
  end

  assign rvalid = r_rdTag;
  assign rdata  = (|r_rdTag) ? mem_dout0 : '0;

endmodule

// File: tb/tb_single_arg_port_arbiter.sv
// Self-checking bench for single_arg_port_arbiter: directed scenarios then randomized traffic,
// checked against a cycle-level behavioural model of the arbitration rules.
module tb_single_arg_port_arbiter;

  logic         clk;
  logic         rst;
  logic         done;
  logic [3:0]   req_ce;
  logic [3:0]   req_we;
  logic [127:0] req_din;
  logic [3:0]   grant;
  logic [3:0]   rvalid;
  logic [31:0]  rdata;
  logic         ce0;
  logic         we0;
  logic [31:0]  mem_din0;
  logic [31:0]  mem_dout0;

  logic [31:0]  storeMem;

  int          checkCount;
  int          passCount;
  int          failCount;
  int          mPtr;
  int          mPend;
  logic [31:0] mPendData;
  logic [31:0] mMem;
  logic [3:0]  lastGrant;
  logic [3:0]  lastRvalid;
  logic [31:0] lastRdata;

  single_arg_port_arbiter #(
    .NUM_REQ(4),
    .DATA_WIDTH(32)
  ) dut (
    .clk(clk),
    .rst(rst),
    .done(done),
    .req_ce(req_ce),
    .req_we(req_we),
    .req_din(req_din),
    .grant(grant),
    .rvalid(rvalid),
    .rdata(rdata),
    .ce0(ce0),
    .we0(we0),
    .mem_din0(mem_din0),
    .mem_dout0(mem_dout0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scalar argument storage: one-cycle read latency, write on a granted write.
  always @(posedge clk) begin
    if (ce0) begin
      if (we0) storeMem <= mem_din0;
      else     mem_dout0 <= storeMem;
    end
  end

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    assert (obs === exp) passCount++;
    else begin
      failCount++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int pickIdx(input logic [3:0] ce);
`ifdef SINGLE_ARG_ARB_FIXED_PRIO_EN
    for (int k = 0; k < 4; k++) if (ce[k]) return k;
`else
    for (int k = 0; k < 4; k++) if (ce[(mPtr + k) % 4]) return (mPtr + k) % 4;
`endif
    return -1;
  endfunction

  // Compares the settled outputs against the model, then advances the model across the
  // upcoming rising edge.
  task automatic checkOutput();
    int          expIdx;
    logic [3:0]  expGrant;
    logic [3:0]  expRv;
    logic [31:0] expRd;
    if (rst) begin
      mPtr  = 0;
      mPend = -1;
    end
    expIdx   = (rst || done) ? -1 : pickIdx(req_ce);
    expGrant = (expIdx < 0) ? 4'd0 : 4'(1 << expIdx);
    expRv    = (mPend < 0) ? 4'd0 : 4'(1 << mPend);
    expRd    = (mPend < 0) ? 32'd0 : mPendData;
    checkVal("grant", {28'd0, grant}, {28'd0, expGrant});
    checkVal("ce0", {31'd0, ce0}, {31'd0, expIdx >= 0});
    checkVal("we0", {31'd0, we0}, {31'd0, (expIdx >= 0) ? req_we[expIdx] : 1'b0});
    checkVal("mem_din0", mem_din0, (expIdx >= 0) ? req_din[expIdx*32 +: 32] : 32'd0);
    checkVal("rvalid", {28'd0, rvalid}, {28'd0, expRv});
    checkVal("rdata", rdata, expRd);
    lastGrant  = grant;
    lastRvalid = rvalid;
    lastRdata  = rdata;
    if (!rst) begin
      mPend = (expIdx >= 0 && !req_we[expIdx]) ? expIdx : -1;
      mPendData = mMem;
      if (expIdx >= 0) begin
        if (req_we[expIdx]) mMem = req_din[expIdx*32 +: 32];
`ifdef SINGLE_ARG_ARB_FIXED_PRIO_EN
        mPtr = 0;
`else
        mPtr = (expIdx + 1) % 4;
`endif
      end
    end
  endtask

  task automatic applyStimulus(input logic r, input logic [3:0] ce, input logic [3:0] we,
                               input logic [127:0] din, input logic dn);
    rst     = r;
    req_ce  = ce;
    req_we  = we;
    req_din = din;
    done    = dn;
    #1;
    checkOutput();
    @(negedge clk);
  endtask

  initial begin
    logic [127:0] din;
    checkCount = 0;
    passCount  = 0;
    failCount  = 0;
    mPtr       = 0;
    mPend      = -1;
    mPendData  = '0;
    mMem       = '0;
    storeMem   = '0;
    mem_dout0  = '0;
    rst        = 1'b1;
    done       = 1'b0;
    req_ce     = '0;
    req_we     = '0;
    req_din    = '0;
    @(negedge clk);

    applyStimulus(1'b1, 4'b1111, 4'b0000, '0, 1'b0);
    checkVal("reset_grant", {28'd0, lastGrant}, 32'd0);
    applyStimulus(1'b1, 4'b1111, 4'b0000, '0, 1'b0);

    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b0, 4'b1111, 4'b0000, {4{32'h1000_0000 + 32'(i)}}, 1'b0);
`ifndef SINGLE_ARG_ARB_FIXED_PRIO_EN
      checkVal("rr_grant", {28'd0, lastGrant}, 32'(4'b0001 << (i % 4)));
`endif
    end

    din = '0;
    din[64 +: 32] = 32'hDEADBEEF;
    applyStimulus(1'b0, 4'b0100, 4'b0100, din, 1'b0);
    checkVal("wr_we0_seen", {28'd0, lastGrant}, 32'h4);
    applyStimulus(1'b0, 4'b0010, 4'b0000, '0, 1'b0);
    applyStimulus(1'b0, 4'b0000, 4'b0000, '0, 1'b0);
    checkVal("rd_rvalid", {28'd0, lastRvalid}, 32'h2);
    checkVal("rd_rdata", lastRdata, 32'hDEADBEEF);

    applyStimulus(1'b0, 4'b0001, 4'b0000, '0, 1'b0);
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 4'b0101, 4'b0000, '0, 1'b1);
    applyStimulus(1'b0, 4'b0101, 4'b0000, '0, 1'b0);
`ifndef SINGLE_ARG_ARB_FIXED_PRIO_EN
    checkVal("thaw_grant", {28'd0, lastGrant}, 32'h4);
`endif

    applyStimulus(1'b0, 4'b1000, 4'b0000, '0, 1'b0);
    applyStimulus(1'b0, 4'b0000, 4'b0000, '0, 1'b1);
    checkVal("rd_across_done", {28'd0, lastRvalid}, 32'h8);
    applyStimulus(1'b0, 4'b0000, 4'b0000, '0, 1'b0);

    applyStimulus(1'b0, 4'b0001, 4'b0000, '0, 1'b0);
    applyStimulus(1'b1, 4'b0000, 4'b0000, '0, 1'b0);
    checkVal("rst_kills_rvalid", {28'd0, lastRvalid}, 32'h0);
    applyStimulus(1'b0, 4'b0000, 4'b0000, '0, 1'b0);

`ifdef SINGLE_ARG_ARB_FIXED_PRIO_EN
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 4'b0110, 4'b0000, '0, 1'b0);
      checkVal("fixed_grant", {28'd0, lastGrant}, 32'h2);
    end
`endif

    for (int i = 0; i < 400; i++) begin
      din = {$urandom, $urandom, $urandom, $urandom};
      applyStimulus(($urandom_range(0, 63) == 0), 4'($urandom), 4'($urandom), din,
                    ($urandom_range(0, 7) == 0));
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
